// File: rtl/nr_div_pkg.sv
// rtl/nr_div_pkg.sv - shared types and width helpers for the non-restoring divider
package nr_div_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic logic [31:0] max_pos(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] min_neg(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/nr_div_step.sv
// rtl/nr_div_step.sv - one combinational non-restoring add/sub-and-shift iteration
module nr_div_step
  import nr_div_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [W:0]   p_in,
  input  logic         bit_in,
  input  logic [W-1:0] d_in,
  output logic [W:0]   p_out,
  output logic         q_bit
);

  logic [W:0] p_sh;
  logic [W:0] d_ext;

  assign p_sh  = {p_in[W-1:0], bit_in};
  assign d_ext = {1'b0, d_in};
  assign p_out = p_in[W] ? (p_sh + d_ext) : (p_sh - d_ext);
  assign q_bit = ~p_out[W];

endmodule

// File: rtl/nr_seq_divider.sv
// rtl/nr_seq_divider.sv - sequential signed non-restoring divider, one step per clock
// NRDIV_SAT_EN selects saturating overflow / divide-by-zero quotients.
module nr_seq_divider
  import nr_div_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cnt_width(W);
`ifdef NRDIV_SAT_EN
  localparam logic [W-1:0] Q_MAX = W'(max_pos(W));
  localparam logic [W-1:0] Q_MIN = W'(min_neg(W));
`endif

  state_t          state_q, state_d;
  logic [W:0]      p_q, p_d;
  logic [W-1:0]    q_q, q_d, d_q, d_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_dvd_q, neg_dvd_d, neg_quo_q, neg_quo_d, dz_q, dz_d;
  logic            busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [W-1:0]    quo_q, quo_d, rem_q, rem_d;

  logic [W:0]      step_p;
  logic            step_qb;
  logic [W-1:0]    dvd_mag, dsr_mag, rem_mag, quo_fix, rem_fix;

  nr_div_step #(.W(W)) u_step (
    .p_in  (p_q),
    .bit_in(q_q[W-1]),
    .d_in  (d_q),
    .p_out (step_p),
    .q_bit (step_qb)
  );

  assign dvd_mag = dividend[W-1] ? -dividend : dividend;
  assign dsr_mag = divisor[W-1]  ? -divisor  : divisor;

  // Remainder correction fits in W bits since the corrected value is below |divisor|.
  assign rem_mag = p_q[W] ? (p_q[W-1:0] + d_q) : p_q[W-1:0];

  always_comb begin
    if (dz_q) begin
      rem_fix = neg_dvd_q ? -q_q : q_q;
`ifdef NRDIV_SAT_EN
      quo_fix = neg_dvd_q ? Q_MIN : Q_MAX;
`else
      quo_fix = '1;
`endif
    end else begin
      rem_fix = neg_dvd_q ? -rem_mag : rem_mag;
      quo_fix = neg_quo_q ? -q_q : q_q;
`ifdef NRDIV_SAT_EN
      if (!neg_quo_q && q_q[W-1]) quo_fix = Q_MAX;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    q_d       = q_q;
    d_d       = d_q;
    cnt_d     = cnt_q;
    neg_dvd_d = neg_dvd_q;
    neg_quo_d = neg_quo_q;
    dz_d      = dz_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d    = 1'b1;
          dbz_d     = 1'b0;
          p_d       = '0;
          q_d       = dvd_mag;
          d_d       = dsr_mag;
          cnt_d     = CW'(W);
          neg_dvd_d = dividend[W-1];
          neg_quo_d = dividend[W-1] ^ divisor[W-1];
          dz_d      = (divisor == '0);
          // Zero divisor skips the iterations but still passes through FIX for result selection.
          state_d   = (divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        p_d   = step_p;
        q_d   = {q_q[W-2:0], step_qb};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        quo_d   = quo_fix;
        rem_d   = rem_fix;
        dbz_d   = dz_q;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      p_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      neg_dvd_q <= 1'b0;
      neg_quo_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      q_q       <= q_d;
      d_q       <= d_d;
      cnt_q     <= cnt_d;
      neg_dvd_q <= neg_dvd_d;
      neg_quo_q <= neg_quo_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nr_seq_divider.sv
// tb/tb_nr_seq_divider.sv - self-checking bench for nr_seq_divider (W=8), NRDIV_SAT_EN aware
module tb_nr_seq_divider;

`ifdef NRDIV_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int n_pass = 0;
  int n_total = 0;
  int last_q = 0;
  int last_r = 0;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    bit dz;
    int lat;
  } vec_t;

  vec_t vecs[$];

  nr_seq_divider #(.W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic int sq(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  // Reference: plain integer division with the documented special cases.
  task automatic model(input int a, input int b, output int q, output int r, output bit dz);
    dz = (b == 0);
    if (b == 0) begin
      r = a;
      q = SAT ? ((a >= 0) ? 127 : -128) : -1;
    end else if (a == -128 && b == -1) begin
      r = 0;
      q = SAT ? 127 : -128;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge of the cycle after done.
  task automatic run_div(input int a, input int b, input int exp_q, input int exp_r,
                         input bit exp_dz, input int exp_lat, input int pulse_at, input bit poke_done);
    int lat;
    int busy_low;
    logic [7:0] av, bv;
    av = a[7:0];
    bv = b[7:0];
    dividend = av;
    divisor  = bv;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    lat      = 1;
    busy_low = 0;
    while (lat <= 40) begin
      if (!busy) busy_low++;
      if (lat == 1) chk("dbz_cleared_on_start", int'(div_by_zero), 0);
      if (lat == exp_lat - 1) begin
        chk("quotient_held", sq(quotient), last_q);
        chk("remainder_held", sq(remainder), last_r);
      end
      if (pulse_at > 0) begin
        start = (lat == pulse_at);
        if (lat == pulse_at) begin
          dividend = 8'd9;
          divisor  = 8'd2;
        end
      end
      if (done) break;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, exp_lat);
    chk("busy_through_done", busy_low, 0);
    chk("quotient", sq(quotient), exp_q);
    chk("remainder", sq(remainder), exp_r);
    chk("div_by_zero", int'(div_by_zero), int'(exp_dz));
    last_q = exp_q;
    last_r = exp_r;
    if (poke_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_single_pulse", int'(done), 0);
    chk("busy_after_done", int'(busy), 0);
    chk("quotient_after_done", sq(quotient), exp_q);
  endtask

  initial begin
    vecs.push_back('{a:  100, b:    7, q:  14,                   r:    2, dz: 1'b0, lat: 10});
    vecs.push_back('{a: -100, b:    7, q: -14,                   r:   -2, dz: 1'b0, lat: 10});
    vecs.push_back('{a:  100, b:   -7, q: -14,                   r:    2, dz: 1'b0, lat: 10});
    vecs.push_back('{a: -100, b:   -7, q:  14,                   r:   -2, dz: 1'b0, lat: 10});
    vecs.push_back('{a: -128, b:   -1, q: SAT ? 127 : -128,      r:    0, dz: 1'b0, lat: 10});
    vecs.push_back('{a:    5, b:    0, q: SAT ? 127 : -1,        r:    5, dz: 1'b1, lat:  2});
    vecs.push_back('{a:    9, b:    2, q:   4,                   r:    1, dz: 1'b0, lat: 10});
    vecs.push_back('{a: -128, b:    1, q: -128,                  r:    0, dz: 1'b0, lat: 10});
    vecs.push_back('{a:  127, b: -128, q:   0,                   r:  127, dz: 1'b0, lat: 10});
    vecs.push_back('{a: -128, b: -128, q:   1,                   r:    0, dz: 1'b0, lat: 10});
    vecs.push_back('{a:   -5, b:    0, q: SAT ? -128 : -1,       r:   -5, dz: 1'b1, lat:  2});
    vecs.push_back('{a:    0, b:    5, q:   0,                   r:    0, dz: 1'b0, lat: 10});
    vecs.push_back('{a:    7, b:  100, q:   0,                   r:    7, dz: 1'b0, lat: 10});
    vecs.push_back('{a:   -1, b:    1, q:  -1,                   r:    0, dz: 1'b0, lat: 10});

    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_quotient", sq(quotient), 0);
    chk("reset_remainder", sq(remainder), 0);
    chk("reset_dbz", int'(div_by_zero), 0);
    rst = 1'b0;

    foreach (vecs[i])
      run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat, -1, 1'b0);

    // start while busy must not disturb the running division
    run_div(50, 3, 16, 2, 1'b0, 10, 4, 1'b0);
    // start presented only during the done cycle must not be accepted
    run_div(9, 2, 4, 1, 1'b0, 10, -1, 1'b1);

    // reset in the middle of an operation
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_done", int'(done), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_quotient", sq(quotient), 0);
    chk("midrst_remainder", sq(remainder), 0);
    rst    = 1'b0;
    last_q = 0;
    last_r = 0;
    run_div(9, 2, 4, 1, 1'b0, 10, -1, 1'b0);

    for (int n = 0; n < 150; n++) begin
      int a, b, eq, er;
      bit edz;
      logic [7:0] ra, rb;
      int pick;
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      a    = sq(ra);
      b    = sq(rb);
      pick = $urandom_range(0, 9);
      if (pick == 0) b = 0;
      if (pick == 1) begin
        a = -128;
        b = -1;
      end
      if (pick == 2) a = -128;
      model(a, b, eq, er, edz);
      run_div(a, b, eq, er, edz, edz ? 2 : 10, -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
